// File: rtl/filter_deconv_if.sv
// Sample stream bundle for filter_deconv: filtered input y[n] in, recovered x[n] out.
interface filter_deconv_if;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               in_ready;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/filter_deconv.sv
// Inverse IIR stage: x[n] = (y[n] + C_Y1*y[n-1] + C_X1*x[n-1] + C_X2*x[n-2]) >>> SHIFT.
// Define DECONV_SAT_EN to saturate the 16-bit result; otherwise it wraps.
module filter_deconv #(
    parameter int          C_Y1  = 27,
    parameter int          C_X1  = 6,
    parameter int          C_X2  = -18,
    parameter int unsigned SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    filter_deconv_if.slave   bus,
    output logic             warm
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD} state_t;

    localparam logic signed [39:0] K_Y1 = 40'(C_Y1);
    localparam logic signed [39:0] K_X1 = 40'(C_X1);
    localparam logic signed [39:0] K_X2 = 40'(C_X2);

    state_t             r_state;
    logic signed [15:0] r_y0;
    logic signed [15:0] r_y1;
    logic signed [15:0] r_x1;
    logic signed [15:0] r_x2;
    logic signed [15:0] r_out_data;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_warm;
    logic [1:0]         r_cnt;

    logic signed [39:0] w_sum;
    logic signed [15:0] w_narrow;

    assign w_sum = 40'(r_y0) + K_Y1 * 40'(r_y1) + K_X1 * 40'(r_x1) + K_X2 * 40'(r_x2);

`ifdef DECONV_SAT_EN
    logic signed [39:0] w_shift;
    assign w_shift  = w_sum >>> SHIFT;
    assign w_narrow = (w_shift > 40'sd32767)  ? 16'sh7fff :
                      (w_shift < -40'sd32768) ? 16'sh8000 : w_shift[15:0];
`else
    assign w_narrow = 16'(w_sum >>> SHIFT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_y0        <= '0;
            r_y1        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_warm      <= 1'b0;
            r_cnt       <= '0;
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_y0        <= '0;
            r_y1        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_warm      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // in_ready comes up one edge after reset release, so no accept on that edge
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_y0       <= bus.in_data;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_out_data  <= w_narrow;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_y1        <= r_y0;
                        r_x2        <= r_x1;
                        r_x1        <= r_out_data;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_cnt       <= (r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1;
                        r_warm      <= (r_cnt != 2'd0);
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign warm          = r_warm;

endmodule

// File: tb/tb_filter_deconv.sv
// Scoreboard bench for filter_deconv; build with +define+DECONV_SAT_EN to cover the saturating variant.
module tb_filter_deconv;

    localparam longint K_Y1 = 27;
    localparam longint K_X1 = 6;
    localparam longint K_X2 = -18;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic warm;

    filter_deconv_if bus_if ();

    filter_deconv #(
        .C_Y1 (27),
        .C_X1 (6),
        .C_X2 (-18),
        .SHIFT(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .bus  (bus_if.slave),
        .warm (warm)
    );

    always #5 clk = ~clk;

    int     n_checks  = 0;
    int     n_err     = 0;
    int     delivered = 0;
    longint exp_q[$];
    longint m_y1 = 0, m_x1 = 0, m_x2 = 0;
    bit     rnd_done = 1'b0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic longint narrow(input longint v);
`ifdef DECONV_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        logic signed [15:0] t;
        t = v[15:0];
        return longint'(t);
`endif
    endfunction

    // Reference recurrence on plain integers; history advances as each sample is issued.
    function automatic longint model(input longint y);
        longint acc, x;
        acc  = y + K_Y1 * m_y1 + K_X1 * m_x1 + K_X2 * m_x2;
        x    = narrow(acc >>> 1);
        m_x2 = m_x1;
        m_x1 = x;
        m_y1 = y;
        return x;
    endfunction

    function automatic void flush_model();
        exp_q.delete();
        m_y1 = 0;
        m_x1 = 0;
        m_x2 = 0;
        delivered = 0;
    endfunction

    // Monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && !clear && bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_output: got %0d expected none at %0t", bus_if.out_data, $time);
            end else begin
                chk("out_data", bus_if.out_data, exp_q.pop_front());
                chk("warm_at_delivery", warm, longint'(delivered >= 2));
            end
            delivered = (delivered < 3) ? delivered + 1 : 3;
        end
    end

    task automatic send(input logic signed [15:0] y, input bit use_exp, input longint ex);
        longint m;
        int     k;
        k = 0;
        m = model(y);
        while (!bus_if.in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus_if.in_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
        end else begin
            exp_q.push_back(use_exp ? ex : m);
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = y;
            @(posedge clk); #1;
            bus_if.in_valid = 1'b0;
            bus_if.in_data  = 16'($urandom);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0 at %0t", exp_q.size(), $time);
            exp_q.delete();
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        flush_model();
        @(posedge clk); #1;
        chk("rst_in_ready", bus_if.in_ready, 0);
        chk("rst_out_valid", bus_if.out_valid, 0);
        chk("rst_out_data", bus_if.out_data, 0);
        chk("rst_warm", warm, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_release", bus_if.in_ready, 1);
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b1;

        // Impulse
        reset_dut();
        send(100, 1, 50);
        drain();
        chk("warm_after_1", warm, 0);
        send(0, 1, 1500);
        drain();
        chk("warm_after_2", warm, 1);
        send(0, 1, 4050);
        drain();

        // Floor shift on a negative accumulator
        reset_dut();
        send(-3, 1, -2);
        drain();

        // Width rule
        reset_dut();
        send(32767, 1, 16383);
`ifdef DECONV_SAT_EN
        send(32767, 1, 32767);
`else
        send(32767, 1, -16401);
`endif
        drain();

        // Backpressure in HOLD
        reset_dut();
        bus_if.out_ready = 1'b0;
        send(100, 1, 50);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            bus_if.in_valid = (i % 2) == 0;
            bus_if.in_data  = 16'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", bus_if.out_valid, 1);
            chk("bp_out_data", bus_if.out_data, 50);
            chk("bp_in_ready", bus_if.in_ready, 0);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        drain();
        send(0, 1, 1500);
        drain();

        // Clear while holding a result
        reset_dut();
        bus_if.out_ready = 1'b0;
        send(100, 1, 50);
        @(posedge clk); #1;
        chk("pre_clear_out_valid", bus_if.out_valid, 1);
        clear = 1'b1;
        flush_model();
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_out_valid", bus_if.out_valid, 0);
        bus_if.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        send(100, 1, 50);
        drain();
        chk("warm_after_clear", warm, 0);

        // Asynchronous reset while a sample is in CALC
        reset_dut();
        send(100, 1, 50);
        send(0, 1, 1500);
        drain();
        chk("warm_before_areset", warm, 1);
        send(5, 0, 0);
        rst_n = 1'b0;
        flush_model();
        #1;
        chk("areset_in_ready", bus_if.in_ready, 0);
        chk("areset_out_valid", bus_if.out_valid, 0);
        chk("areset_out_data", bus_if.out_data, 0);
        chk("areset_warm", warm, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("areset_release_in_ready", bus_if.in_ready, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        send(100, 1, 50);
        drain();

        // Randomized traffic with random backpressure
        reset_dut();
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    logic signed [15:0] y;
                    if (n % 3 == 0) y = 16'($urandom_range(0, 65535));
                    else            y = 16'($signed($urandom_range(0, 400)) - 200);
                    send(y, 0, 0);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                for (int k = 0; k < 3000 && !rnd_done; k++) begin
                    @(posedge clk); #1;
                    bus_if.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus_if.out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
